// File: rtl/systolic_mm_core.sv
// NxN output-stationary systolic matrix multiply, C = A*B, with the inner dimension K set per job.
// Latency: the result is valid 2N edges after the last accepted operand beat; done pulses for one cycle.
// Backpressure: in_ready is high only in FEED; cycles without a beat inject zero bubbles. start is ignored while busy.
module systolic_mm_core #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 32,
  parameter int KW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DW-1:0]     a_col,
  input  logic [N*DW-1:0]     b_row,
  output logic                busy,
  output logic                out_valid,
  output logic                done,
  output logic [N*N*AW-1:0]   result
);

  localparam int CW = (2 * N > 2) ? $clog2(2 * N) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   beat_cnt;
  logic [CW-1:0]   drain_cnt;
  logic            done_q;
  logic            accept;
  logic            start_go;
  logic            last_beat;

  assign accept    = in_valid & in_ready;
  assign start_go  = start & ((state == S_IDLE) | (state == S_DONE));
  assign last_beat = accept & (beat_cnt == (k_reg - KW'(1)));
  assign out_valid = (state == S_DONE);
  assign done      = done_q;

  // Next-state and handshake decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = (k_len == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_beat) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register, job length, beat/drain counters and the one-shot completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (start_go) k_reg <= k_len;
      if (start_go) beat_cnt <= '0;
      else if (accept) beat_cnt <= beat_cnt + KW'(1);
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + CW'(1) : '0;
      // Pulse on every entry into DONE, including a zero-length job restarted from DONE.
      done_q    <= (state_nxt == S_DONE) && ((state != S_DONE) || start_go);
    end
  end

  logic signed [DW-1:0]   a_edge [N];
  logic signed [DW-1:0]   b_edge [N];
  logic signed [DW-1:0]   a_in   [N][N];
  logic signed [DW-1:0]   b_in   [N][N];
  logic signed [DW-1:0]   a_pe   [N][N];
  logic signed [DW-1:0]   b_pe   [N][N];
  logic signed [2*DW-1:0] prod   [N][N];
  logic [AW-1:0]          prod_ext [N][N];
  logic [AW-1:0]          acc    [N][N];

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    // Stage 0 captures the beat (zero when none is accepted); row/column gi sees gi more stages.
    logic [DW-1:0] a_sr [gi+1];
    logic [DW-1:0] b_sr [gi+1];

    // Input capture plus skew delay line for A row gi and B column gi.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d <= gi; d++) begin
          a_sr[d] <= '0;
          b_sr[d] <= '0;
        end
      end else if (start_go) begin
        for (int d = 0; d <= gi; d++) begin
          a_sr[d] <= '0;
          b_sr[d] <= '0;
        end
      end else begin
        a_sr[0] <= accept ? a_col[DW*gi +: DW] : '0;
        b_sr[0] <= accept ? b_row[DW*gi +: DW] : '0;
        for (int d = 1; d <= gi; d++) begin
          a_sr[d] <= a_sr[d-1];
          b_sr[d] <= b_sr[d-1];
        end
      end
    end

    assign a_edge[gi] = a_sr[gi];
    assign b_edge[gi] = b_sr[gi];
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      if (gj == 0) begin : g_a_edge
        assign a_in[gi][gj] = a_edge[gi];
      end else begin : g_a_left
        assign a_in[gi][gj] = a_pe[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in[gi][gj] = b_edge[gj];
      end else begin : g_b_up
        assign b_in[gi][gj] = b_pe[gi-1][gj];
      end
      assign prod[gi][gj]     = a_pe[gi][gj] * b_pe[gi][gj];
      // Signed cast: sign-extends when AW is wider than the product, truncates otherwise.
      assign prod_ext[gi][gj] = AW'(prod[gi][gj]);
      assign result[AW*(gi*N+gj) +: AW] = acc[gi][gj];
    end
  end

  // PE operand pipes shift every cycle; accumulators only integrate while a job is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          acc[i][j]  <= '0;
        end
      end
    end else if (start_go) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          acc[i][j]  <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_pe[i][j] <= a_in[i][j];
          b_pe[i][j] <= b_in[i][j];
          if (busy) acc[i][j] <= acc[i][j] + prod_ext[i][j];
        end
      end
    end
  end

endmodule
